// File: rtl/four_requester_round_robin_mux_arbiter.sv
// Round-robin arbiter for four packet requesters sharing one datapath, with a
// single-entry registered output stage. States: IDLE (re-arbitrate) | BUSY (grant held to LAST).
module four_requester_round_robin_mux_arbiter #(
    parameter int BITS = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [3:0]           REQ,
    input  logic [3:0]           LAST,
    input  logic [3:0][BITS-1:0] DATA,
    output logic [3:0]           READY,
    output logic [3:0]           GRANT,
    output logic [1:0]           SELECT,
    output logic                 BUSY,
    output logic [BITS-1:0]      OUT_DATA,
    output logic                 OUT_VALID,
    output logic                 OUT_LAST,
    input  logic                 OUT_READY
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      select_q, select_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic [BITS-1:0] mux_data;
    logic            slot_free;
    logic            accept;
    logic            found;
    logic [1:0]      cand;
    logic [1:0]      pick;

    always_comb begin
        case (select_q)
            2'd0:    mux_data = DATA[0];
            2'd1:    mux_data = DATA[1];
            2'd2:    mux_data = DATA[2];
            default: mux_data = DATA[3];
        endcase
    end

    // The output slot can take a beat when empty or when it is being popped.
    assign slot_free = ~out_valid_q | OUT_READY;
    assign accept    = (state_q == ST_BUSY) & REQ[select_q] & slot_free;

    always_comb begin
        READY = '0;
        if (state_q == ST_BUSY) READY[select_q] = slot_free;
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        select_d    = select_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~OUT_READY;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_BUSY;
                    grant_d  = 4'b0001 << pick;
                    select_d = pick;
                end
            end
            default: begin
                if (accept && LAST[select_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = select_q;
                end
            end
        endcase

        if (accept) begin
            out_data_d  = mux_data;
            out_last_d  = LAST[select_q];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            select_q    <= '0;
            ptr_q       <= 2'd3;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            select_q    <= select_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign GRANT     = grant_q;
    assign SELECT    = select_q;
    assign BUSY      = (state_q == ST_BUSY);
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_four_requester_round_robin_mux_arbiter.sv
// Directed bench for the four-requester round-robin arbiter; expected values are hand-computed.
module tb_four_requester_round_robin_mux_arbiter;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [3:0]       REQ;
    logic [3:0]       LAST;
    logic [3:0][31:0] DATA;
    logic [3:0]       READY;
    logic [3:0]       GRANT;
    logic [1:0]       SELECT;
    logic             BUSY;
    logic [31:0]      OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_LAST;
    logic             OUT_READY;

    int vectors    = 0;
    int miscompares = 0;

    four_requester_round_robin_mux_arbiter #(.BITS(32)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .LAST(LAST), .DATA(DATA),
        .READY(READY), .GRANT(GRANT), .SELECT(SELECT), .BUSY(BUSY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ = '0; LAST = '0; DATA = '0; OUT_READY = 1'b1;
        #3;
        vectors++; if (GRANT !== 4'b0000) begin miscompares++; $display("FAIL rst_grant: got %b expected 0000", GRANT); end
        vectors++; if (SELECT !== 2'd0) begin miscompares++; $display("FAIL rst_select: got %0d expected 0", SELECT); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
        vectors++; if ({OUT_VALID, OUT_LAST} !== 2'b00) begin miscompares++; $display("FAIL rst_out_flags: got %b expected 00", {OUT_VALID, OUT_LAST}); end
        vectors++; if (OUT_DATA !== 32'h0) begin miscompares++; $display("FAIL rst_out_data: got %h expected 0", OUT_DATA); end
        vectors++; if (READY !== 4'b0000) begin miscompares++; $display("FAIL rst_ready: got %b expected 0000", READY); end
        step();
        RESET = 1'b0;
    endtask

    task automatic test_single_beat();
        REQ = 4'b0001; LAST = 4'b0001; DATA[0] = 32'hA5A5_A5A5; OUT_READY = 1'b1;
        #1;
        vectors++; if (READY !== 4'b0000) begin miscompares++; $display("FAIL single_idle_ready: got %b expected 0000", READY); end
        step();
        vectors++; if (GRANT !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b expected 0001", GRANT); end
        vectors++; if (SELECT !== 2'd0) begin miscompares++; $display("FAIL single_select: got %0d expected 0", SELECT); end
        vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", BUSY); end
        vectors++; if (READY !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b expected 0001", READY); end
        step();
        REQ = '0;
        vectors++; if (OUT_DATA !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL single_data: got %h expected a5a5a5a5", OUT_DATA); end
        vectors++; if ({OUT_VALID, OUT_LAST} !== 2'b11) begin miscompares++; $display("FAIL single_out_flags: got %b expected 11", {OUT_VALID, OUT_LAST}); end
        vectors++; if ({BUSY, GRANT} !== 5'b0) begin miscompares++; $display("FAIL single_release: got %b expected 00000", {BUSY, GRANT}); end
        step();
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_round_robin();
        int order [4] = '{1, 2, 3, 0};
        REQ = 4'b1111; LAST = 4'b1111;
        DATA[0] = 32'h0000_00D0; DATA[1] = 32'h0000_00D1; DATA[2] = 32'h0000_00D2; DATA[3] = 32'h0000_00D3;
        for (int n = 0; n < 4; n++) begin
            step();
            vectors++; if (GRANT !== (4'b0001 << order[n])) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected idx %0d", n, GRANT, order[n]); end
            vectors++; if (SELECT !== 2'(order[n])) begin miscompares++; $display("FAIL rr_select[%0d]: got %0d expected %0d", n, SELECT, order[n]); end
            step();
            vectors++; if ({BUSY, GRANT} !== 5'b0) begin miscompares++; $display("FAIL rr_bubble[%0d]: got %b expected 00000", n, {BUSY, GRANT}); end
            vectors++; if (OUT_DATA !== 32'hD0 + 32'(order[n])) begin miscompares++; $display("FAIL rr_data[%0d]: got %h expected %h", n, OUT_DATA, 32'hD0 + 32'(order[n])); end
            vectors++; if (dut.ptr_q !== 2'(order[n])) begin miscompares++; $display("FAIL rr_ptr[%0d]: got %0d expected %0d", n, dut.ptr_q, order[n]); end
        end
        REQ = '0;
        step();
    endtask

    task automatic test_multi_beat();
        REQ = 4'b0101; LAST = 4'b0001; DATA[2] = 32'h1; DATA[0] = 32'hC0;
        step();
        vectors++; if (GRANT !== 4'b0100) begin miscompares++; $display("FAIL mb_grant0: got %b expected 0100", GRANT); end
        vectors++; if (READY !== 4'b0100) begin miscompares++; $display("FAIL mb_ready: got %b expected 0100", READY); end
        step();
        DATA[2] = 32'h2;
        vectors++; if (GRANT !== 4'b0100) begin miscompares++; $display("FAIL mb_grant1: got %b expected 0100", GRANT); end
        vectors++; if ({OUT_DATA, OUT_LAST} !== {32'h1, 1'b0}) begin miscompares++; $display("FAIL mb_beat1: got %h/%b expected 1/0", OUT_DATA, OUT_LAST); end
        step();
        DATA[2] = 32'h3; LAST = 4'b0101;
        vectors++; if (GRANT !== 4'b0100) begin miscompares++; $display("FAIL mb_grant2: got %b expected 0100", GRANT); end
        vectors++; if ({OUT_DATA, OUT_LAST} !== {32'h2, 1'b0}) begin miscompares++; $display("FAIL mb_beat2: got %h/%b expected 2/0", OUT_DATA, OUT_LAST); end
        step();
        REQ = 4'b0001;
        vectors++; if (GRANT !== 4'b0000) begin miscompares++; $display("FAIL mb_release: got %b expected 0000", GRANT); end
        vectors++; if ({OUT_DATA, OUT_LAST} !== {32'h3, 1'b1}) begin miscompares++; $display("FAIL mb_beat3: got %h/%b expected 3/1", OUT_DATA, OUT_LAST); end
        step();
        vectors++; if (GRANT !== 4'b0001) begin miscompares++; $display("FAIL mb_next_grant: got %b expected 0001", GRANT); end
        step();
        REQ = '0;
        vectors++; if (OUT_DATA !== 32'hC0) begin miscompares++; $display("FAIL mb_next_data: got %h expected c0", OUT_DATA); end
        step();
    endtask

    task automatic test_req_drop();
        REQ = 4'b1010; LAST = 4'b1000; DATA[1] = 32'h101; DATA[3] = 32'h303;
        step();
        vectors++; if (GRANT !== 4'b0010) begin miscompares++; $display("FAIL drop_grant: got %b expected 0010", GRANT); end
        step();
        REQ = 4'b1000;
        vectors++; if (OUT_DATA !== 32'h101) begin miscompares++; $display("FAIL drop_beat1: got %h expected 101", OUT_DATA); end
        for (int n = 0; n < 3; n++) begin
            step();
            vectors++; if ({BUSY, GRANT} !== 5'b10010) begin miscompares++; $display("FAIL drop_hold[%0d]: got %b expected 10010", n, {BUSY, GRANT}); end
        end
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL drop_out_empty: got %b expected 0", OUT_VALID); end
        REQ = 4'b1010; LAST = 4'b1010; DATA[1] = 32'h102;
        step();
        REQ = 4'b1000;
        vectors++; if ({OUT_DATA, OUT_LAST} !== {32'h102, 1'b1}) begin miscompares++; $display("FAIL drop_beat2: got %h/%b expected 102/1", OUT_DATA, OUT_LAST); end
        vectors++; if (GRANT !== 4'b0000) begin miscompares++; $display("FAIL drop_release: got %b expected 0000", GRANT); end
        step();
        vectors++; if (GRANT !== 4'b1000) begin miscompares++; $display("FAIL drop_next_grant: got %b expected 1000", GRANT); end
        step();
        REQ = '0;
        vectors++; if (OUT_DATA !== 32'h303) begin miscompares++; $display("FAIL drop_next_data: got %h expected 303", OUT_DATA); end
        step();
    endtask

    task automatic test_back_pressure();
        REQ = 4'b0010; LAST = 4'b0000; DATA[1] = 32'h11; OUT_READY = 1'b0;
        step();
        vectors++; if (READY !== 4'b0010) begin miscompares++; $display("FAIL bp_ready_empty: got %b expected 0010", READY); end
        step();
        DATA[1] = 32'h22; LAST = 4'b0010;
        vectors++; if (READY !== 4'b0000) begin miscompares++; $display("FAIL bp_ready_full: got %b expected 0000", READY); end
        step();
        vectors++; if ({OUT_VALID, OUT_DATA} !== {1'b1, 32'h11}) begin miscompares++; $display("FAIL bp_stable: got %b/%h expected 1/11", OUT_VALID, OUT_DATA); end
        vectors++; if (READY !== 4'b0000) begin miscompares++; $display("FAIL bp_ready_stall: got %b expected 0000", READY); end
        OUT_READY = 1'b1;
        #1;
        vectors++; if (READY !== 4'b0010) begin miscompares++; $display("FAIL bp_ready_pop: got %b expected 0010", READY); end
        step();
        REQ = '0;
        vectors++; if ({OUT_VALID, OUT_LAST, OUT_DATA} !== {2'b11, 32'h22}) begin miscompares++; $display("FAIL bp_pop_load: got %b%b/%h expected 11/22", OUT_VALID, OUT_LAST, OUT_DATA); end
        step();
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_reset_mid_packet();
        REQ = 4'b0100; LAST = 4'b0000; DATA[2] = 32'h77; OUT_READY = 1'b0;
        step();
        step();
        vectors++; if ({OUT_VALID, GRANT} !== 5'b10100) begin miscompares++; $display("FAIL rm_pre: got %b expected 10100", {OUT_VALID, GRANT}); end
        #2 RESET = 1'b1;
        #1;
        vectors++; if ({OUT_VALID, BUSY, GRANT} !== 6'b0) begin miscompares++; $display("FAIL rm_async: got %b expected 000000", {OUT_VALID, BUSY, GRANT}); end
        vectors++; if (OUT_DATA !== 32'h0) begin miscompares++; $display("FAIL rm_data: got %h expected 0", OUT_DATA); end
        step();
        RESET = 1'b0; REQ = 4'b1111; LAST = 4'b1111; OUT_READY = 1'b1;
        step();
        vectors++; if (GRANT !== 4'b0001) begin miscompares++; $display("FAIL rm_priority: got %b expected 0001", GRANT); end
        REQ = '0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_multi_beat();
        test_req_drop();
        test_back_pressure();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
